// File: rtl/car_game_pkg.sv
// Shared types and constants for the lane-runner player car.
// Holds the game state encoding, the sprite shape classes and the
// 3-bit {R,G,B} colour constants used by the sprite renderer.
package car_game_pkg;

    localparam int H_RES = 640;
    localparam int V_RES = 480;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HIT  = 2'd1,
        ST_OVER = 2'd2
    } car_state_e;

    typedef enum logic [2:0] {
        SH_NONE   = 3'd0,
        SH_BORDER = 3'd1,
        SH_BODY   = 3'd2,
        SH_WINDOW = 3'd3,
        SH_LIGHT  = 3'd4
    } shape_e;

    localparam logic [2:0] RGB_BLACK  = 3'b000;
    localparam logic [2:0] RGB_GREEN  = 3'b010;
    localparam logic [2:0] RGB_BLUE   = 3'b001;
    localparam logic [2:0] RGB_YELLOW = 3'b110;
    localparam logic [2:0] RGB_RED    = 3'b100;

    // Colour of a shape class in normal play; NONE maps to black but is
    // never shown because it also clears spr_on.
    function automatic logic [2:0] shape_rgb(input shape_e s);
        logic [2:0] c;
        case (s)
            SH_BORDER: c = RGB_BLACK;
            SH_BODY:   c = RGB_GREEN;
            SH_WINDOW: c = RGB_BLUE;
            SH_LIGHT:  c = RGB_YELLOW;
            default:   c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/player_car_shape.sv
// Car outline art: maps a sprite-relative coordinate (rx, ry) to a shape
// class. The art is drawn for an 80x110 sprite with the car pointing up:
// headlights at the top, a windscreen and rear window, and a pinched waist
// between the wheel arches where the background shows through.
module player_car_shape
    import car_game_pkg::*;
(
    input  logic [6:0] rx,
    input  logic [6:0] ry,
    output shape_e     shape
);

    // Priority-ordered rectangle tests; earlier rectangles win.
    always_comb begin
        shape = SH_BODY;
        if (rx >= 7'd80 || ry >= 7'd110) begin
            shape = SH_NONE;
        end else if ((rx < 7'd6 || rx >= 7'd74) && ry >= 7'd30 && ry < 7'd80) begin
            shape = SH_NONE;
        end else if ((rx < 7'd8 || rx >= 7'd72) && ry >= 7'd30 && ry < 7'd80) begin
            shape = SH_BORDER;
        end else if (rx < 7'd2 || rx >= 7'd78 || ry < 7'd2 || ry >= 7'd108) begin
            shape = SH_BORDER;
        end else if (ry >= 7'd4 && ry < 7'd12 &&
                     ((rx >= 7'd8 && rx < 7'd22) || (rx >= 7'd58 && rx < 7'd72))) begin
            shape = SH_LIGHT;
        end else if ((ry >= 7'd20 && ry < 7'd40 && rx >= 7'd14 && rx < 7'd66) ||
                     (ry >= 7'd80 && ry < 7'd94 && rx >= 7'd18 && rx < 7'd62)) begin
            shape = SH_WINDOW;
        end
    end

endmodule

// File: rtl/player_sprite_ctrl.sv
// Player car controller and renderer for the N-lane runner.
// Owns x position, lives and the RUN/HIT/OVER state, advancing only on the
// one-cycle tick strobe, and produces a registered sprite pixel.
//
// Optional build macro: RESPAWN_CENTER_EN -- when defined, an accepted hit
// that enters HIT also recentres the car to X_START.
//
// state | meaning
// RUN   | normal play, collisions accepted on tick
// HIT   | invulnerable, timer counts down on tick, sprite blinks
// OVER  | no lives left, everything frozen until reset
module player_sprite_ctrl
    import car_game_pkg::*;
#(
    parameter int H_RES        = car_game_pkg::H_RES,
    parameter int SPR_W        = 80,
    parameter int SPR_H        = 110,
    parameter int Y_TOP        = 350,
    parameter int LANE_X0      = 40,
    parameter int LANE_W       = 140,
    parameter int NUM_LANES    = 4,
    parameter int X_MIN        = 40,
    parameter int X_MAX        = 520,
    parameter int X_START      = 280,
    parameter int STEP         = 2,
    parameter int LIVES        = 3,
    parameter int INVULN_TICKS = 64,
    localparam int LW          = $clog2(NUM_LANES),
    localparam int LVW         = $clog2(LIVES + 1)
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 btn_left_n,
    input  logic                 btn_right_n,
    input  logic [9:0]           px,
    input  logic [8:0]           py,
    input  logic [NUM_LANES-1:0] obstacle_hit,
    output logic [9:0]           x_pos,
    output logic [LW-1:0]        lane_idx,
    output logic [LVW-1:0]       lives_left,
    output logic                 hit_pulse,
    output logic                 game_over,
    output logic                 spr_on,
    output logic [2:0]           spr_rgb
);

    localparam int TW = $clog2(INVULN_TICKS + 1);

    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_HIT  = ST_HIT;
    localparam logic [1:0] S_OVER = ST_OVER;

    logic [1:0]     state, state_next;
    logic [TW-1:0]  timer, timer_next;
    logic [9:0]     x_next;
    logic [LVW-1:0] lives_next;
    logic           hit_next;

    logic [10:0]    x_ext, x_right, x_left, x_moved;
    logic [10:0]    center, lane_q;
    logic [LW-1:0]  lane_calc;
    logic           move_r, move_l, hit_now;

    logic [10:0]    rx_full, ry_full;
    logic           in_x, in_y, blank;
    shape_e         shape;
    logic           pix_on;
    logic [2:0]     pix_rgb;

    assign x_ext  = {1'b0, x_pos};
    assign move_r = !btn_right_n && btn_left_n;
    assign move_l = !btn_left_n && btn_right_n;

    // Saturating one-step move; 11-bit math so the clamp never wraps.
    always_comb begin
        x_right = x_ext + 11'(STEP);
        if (x_right > 11'(X_MAX))
            x_right = 11'(X_MAX);
        if (x_ext < 11'(X_MIN + STEP))
            x_left = 11'(X_MIN);
        else
            x_left = x_ext - 11'(STEP);
        if (move_r)
            x_moved = x_right;
        else if (move_l)
            x_moved = x_left;
        else
            x_moved = x_ext;
    end

    // Lane under the car centre, clamped to the valid lane range.
    always_comb begin
        center    = x_ext + 11'(SPR_W / 2);
        lane_q    = '0;
        lane_calc = '0;
        if (center >= 11'(LANE_X0)) begin
            lane_q = (center - 11'(LANE_X0)) / 11'(LANE_W);
            if (lane_q >= 11'(NUM_LANES - 1))
                lane_calc = LW'(NUM_LANES - 1);
            else
                lane_calc = lane_q[LW-1:0];
        end
    end

    // Collision looks at the registered (pre-move) lane only.
    assign hit_now = obstacle_hit[lane_idx];

    // Next-state logic for the game FSM, position, lives and timer.
    always_comb begin
        state_next = state;
        timer_next = timer;
        x_next     = x_pos;
        lives_next = lives_left;
        hit_next   = 1'b0;
        case (state)
            S_RUN: begin
                if (tick) begin
                    x_next = x_moved[9:0];
                    if (hit_now) begin
                        hit_next   = 1'b1;
                        lives_next = lives_left - LVW'(1);
                        if (lives_left == LVW'(1)) begin
                            state_next = S_OVER;
                        end else begin
                            state_next = S_HIT;
                            timer_next = TW'(INVULN_TICKS);
`ifdef RESPAWN_CENTER_EN
                            x_next     = 10'(X_START);
`endif
                        end
                    end
                end
            end
            S_HIT: begin
                if (tick) begin
                    x_next     = x_moved[9:0];
                    timer_next = timer - TW'(1);
                    if (timer == TW'(1))
                        state_next = S_RUN;
                end
            end
            S_OVER: begin
                state_next = S_OVER;
            end
            default: begin
                state_next = S_RUN;
                timer_next = '0;
            end
        endcase
    end

    // Game state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_RUN;
            timer      <= '0;
            x_pos      <= 10'(X_START);
            lives_left <= LVW'(LIVES);
            hit_pulse  <= 1'b0;
            lane_idx   <= '0;
        end else begin
            state      <= state_next;
            timer      <= timer_next;
            x_pos      <= x_next;
            lives_left <= lives_next;
            hit_pulse  <= hit_next;
            lane_idx   <= lane_calc;
        end
    end

    assign game_over = (state == S_OVER);

    // Sprite-relative coordinates and bounding-box test.
    always_comb begin
        rx_full = {1'b0, px} - x_ext;
        ry_full = {2'b00, py} - 11'(Y_TOP);
        in_x    = (px >= x_pos) && (rx_full < 11'(SPR_W)) && ({1'b0, px} < 11'(H_RES));
        in_y    = ({2'b00, py} >= 11'(Y_TOP)) && (ry_full < 11'(SPR_H));
    end

    player_car_shape u_shape (
        .rx    (rx_full[6:0]),
        .ry    (ry_full[6:0]),
        .shape (shape)
    );

    // Colour selection: red silhouette when the game is over, blink in HIT.
    always_comb begin
        blank   = (state == S_HIT) && timer[2];
        pix_on  = in_x && in_y && (shape != SH_NONE) && !blank;
        pix_rgb = RGB_BLACK;
        if (pix_on)
            pix_rgb = (state == S_OVER) ? RGB_RED : shape_rgb(shape);
    end

    // Registered pixel output, one cycle behind px/py.
    always_ff @(posedge clk) begin
        if (!reset) begin
            spr_on  <= 1'b0;
            spr_rgb <= RGB_BLACK;
        end else begin
            spr_on  <= pix_on;
            spr_rgb <= pix_rgb;
        end
    end

endmodule
